// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined memory port between I/D fills
// and D-cache write-through stores; 8-word block fills.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              i_busy,
    output logic              d_busy,
    output logic              fill_we,
    output logic              fill_sel,
    output logic [2:0]        fill_word,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_done,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid
);

    typedef enum logic {IDLE, FILL} state_t;

    localparam int BLK_W = ADDR_W - 4;

    state_t           state_q;
    logic [3:0]       iss_q;
    logic [2:0]       rcv_q;
    logic [BLK_W-1:0] blk_q;
    logic             sel_q;
    logic             last_q;

    logic             gnt_d;
    logic [BLK_W-1:0] blk_d;
    logic             in_fill;
    logic             issue;
    logic             recv;
    logic             last_word;
    logic             store;

    // Grant selection, issue/receive qualifiers (1 = D side)
    always_comb begin
        gnt_d = d_req;
        if (i_req && d_req) begin
            gnt_d = ~last_q;
        end
        blk_d = gnt_d ? d_addr[ADDR_W-1:4]
                      : i_addr[ADDR_W-1:4];
        in_fill   = (state_q == FILL);
        issue     = in_fill && !iss_q[3];
        recv      = in_fill && mem_valid;
        last_word = recv && (rcv_q == 3'd7);
        store     = !in_fill && wr_req;
    end

    // Control FSM: grant in IDLE, issue and collect 8 words in FILL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            iss_q   <= '0;
            rcv_q   <= '0;
            blk_q   <= '0;
            sel_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!wr_req && (i_req || d_req)) begin
                        state_q <= FILL;
                        sel_q   <= gnt_d;
                        last_q  <= gnt_d;
                        blk_q   <= blk_d;
                        iss_q   <= '0;
                        rcv_q   <= '0;
                    end
                end
                FILL: begin
                    if (issue) begin
                        iss_q <= iss_q + 4'd1;
                    end
                    if (recv) begin
                        rcv_q <= rcv_q + 3'd1;
                    end
                    if (last_word) begin
                        state_q <= IDLE;
                        iss_q   <= '0;
                        rcv_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output decode; everything is forced low while reset is held
    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wr_ack    = 1'b0;
        fill_we   = 1'b0;
        fill_sel  = 1'b0;
        fill_word = '0;
        fill_data = '0;
        fill_done = 1'b0;
        i_busy    = 1'b0;
        d_busy    = 1'b0;
        if (rst_n) begin
            if (store) begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
                wr_ack    = 1'b1;
            end else if (issue) begin
                mem_en   = 1'b1;
                mem_addr = {blk_q, iss_q[2:0], 1'b0};
            end
            if (recv) begin
                fill_we   = 1'b1;
                fill_sel  = sel_q;
                fill_word = rcv_q;
                fill_data = mem_rdata;
                fill_done = last_word;
            end
            i_busy = i_req || (in_fill && !sel_q);
            d_busy = d_req || (in_fill && sel_q)
                  || (wr_req && !store);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench with a 4-cycle memory model.
// Expected reads/fills/writes are queued as stimulus is driven.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, wr_req;
    logic [15:0] i_addr, d_addr, wr_addr, wr_data;
    logic        wr_ack, i_busy, d_busy;
    logic        fill_we, fill_sel, fill_done;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_valid;

    typedef struct {
        logic        sel;
        logic [2:0]  word;
        logic [15:0] data;
    } fill_t;

    logic [15:0] addr_q[$];
    fill_t       fill_q[$];
    logic [31:0] wr_q[$];

    int vecs = 0;
    int errs = 0;

    logic [3:0]  pv = '0;
    logic [15:0] pa [0:3];

    mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_addr(d_addr),
        .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ack(wr_ack),
        .i_busy(i_busy), .d_busy(d_busy),
        .fill_we(fill_we), .fill_sel(fill_sel),
        .fill_word(fill_word), .fill_data(fill_data),
        .fill_done(fill_done),
        .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid)
    );

    always #5 clk = ~clk;

    // memory: read data returns 4 cycles after issue
    always @(posedge clk) begin
        pv <= {pv[2:0], mem_en && !mem_wr};
        pa[0] <= mem_addr;
        for (int i = 1; i < 4; i++) begin
            pa[i] <= pa[i-1];
        end
    end
    assign mem_valid = pv[3];
    assign mem_rdata = pa[3] ^ 16'hA5C3;

    task automatic chk(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h",
                     tag, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fill(input logic sel,
                             input logic [15:0] a);
        logic [15:0] w;
        for (int k = 0; k < 8; k++) begin
            w = {a[15:4], 3'(k), 1'b0};
            addr_q.push_back(w);
            fill_q.push_back('{sel, 3'(k), w ^ 16'hA5C3});
        end
    endtask

    // scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        logic [31:0] e;
        fill_t f;
        if (rst_n) begin
            if (mem_en && !mem_wr) begin
                if (addr_q.size() == 0)
                    chk("rd_unexp", {31'b0, mem_en}, 0);
                else
                    chk("rd_addr", {16'b0, mem_addr},
                        {16'b0, addr_q.pop_front()});
            end
            if (mem_en && mem_wr) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexp", {31'b0, mem_wr}, 0);
                end else begin
                    e = wr_q.pop_front();
                    chk("wr_addr", {16'b0, mem_addr},
                        {16'b0, e[31:16]});
                    chk("wr_data", {16'b0, mem_wdata},
                        {16'b0, e[15:0]});
                    chk("wr_ack", {31'b0, wr_ack}, 1);
                end
            end
            if (fill_we) begin
                if (fill_q.size() == 0) begin
                    chk("fill_unexp", {31'b0, fill_we}, 0);
                end else begin
                    f = fill_q.pop_front();
                    chk("fill_sel", {31'b0, fill_sel},
                        {31'b0, f.sel});
                    chk("fill_word", {29'b0, fill_word},
                        {29'b0, f.word});
                    chk("fill_data", {16'b0, fill_data},
                        {16'b0, f.data});
                    chk("fill_done", {31'b0, fill_done},
                        {31'b0, f.word == 3'd7});
                end
            end else if (fill_done) begin
                chk("done_nowe", {31'b0, fill_done}, 0);
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"},
            {24'b0, mem_en, mem_wr, wr_ack, i_busy,
             d_busy, fill_we, fill_sel, fill_done}, 0);
        chk({tag, "_bus"}, {mem_addr, mem_wdata}, 0);
        chk({tag, "_fill"}, {13'b0, fill_word, fill_data}, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        addr_q.delete();
        fill_q.delete();
        wr_q.delete();
        cycle();
        cycle();
        chk_zero("rst");
        rst_n = 1'b1;
    endtask

    // run from the first FILL cycle until the side's busy falls
    task automatic watch(input bit d_side,
                         output int dn, output int fn,
                         output int en, output int le);
        dn = 0; fn = 0; en = 0; le = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (mem_en && !mem_wr) begin
                en++;
                le = n;
            end
            if (fill_done) dn = n;
            if (!(d_side ? d_busy : i_busy)) begin
                fn = n;
                break;
            end
            cycle();
        end
    endtask

    task automatic both_round(input string tag,
                              input logic [15:0] ia,
                              input logic [15:0] da);
        int dn, fn, en, le;
        cycle();
        i_req = 1; d_req = 1;
        i_addr = ia; d_addr = da;
        push_fill(1'b1, da);
        push_fill(1'b0, ia);
        @(negedge clk);
        chk({tag, "_gbusy"}, {30'b0, i_busy, d_busy}, 3);
        chk({tag, "_gen"}, {31'b0, mem_en}, 0);
        cycle();
        d_req = 0;
        watch(1'b1, dn, fn, en, le);
        chk({tag, "_d_fall"}, fn, 13);
        chk({tag, "_i_wait"}, {31'b0, i_busy}, 1);
        chk({tag, "_i_gen"}, {31'b0, mem_en}, 0);
        cycle();
        i_req = 0;
        watch(1'b0, dn, fn, en, le);
        chk({tag, "_i_fall"}, fn, 13);
    endtask

    initial begin
        int dn, fn, en, le, ack, dbl, stray;
        i_req = 0; d_req = 0; wr_req = 0;
        i_addr = 0; d_addr = 0; wr_addr = 0; wr_data = 0;
        rst_n = 0;
        do_reset();

        // 1: single I fill
        cycle();
        i_req = 1; i_addr = 16'h1236;
        push_fill(1'b0, 16'h1236);
        @(negedge clk);
        chk("t1_gen", {31'b0, mem_en}, 0);
        chk("t1_gbusy", {31'b0, i_busy}, 1);
        cycle();
        i_req = 0;
        watch(1'b0, dn, fn, en, le);
        chk("t1_done", dn, 12);
        chk("t1_fall", fn, 13);
        chk("t1_en", en, 8);
        chk("t1_last", le, 8);

        // 2: simultaneous requests alternate, D first
        cycle();
        do_reset();
        both_round("t2a", 16'h2000, 16'h3010);
        both_round("t2b", 16'h2100, 16'h3120);

        // 3: store wins in IDLE, D fill next
        cycle();
        wr_req = 1; wr_addr = 16'h4000; wr_data = 16'hBEEF;
        d_req = 1; d_addr = 16'h5000;
        wr_q.push_back({16'h4000, 16'hBEEF});
        push_fill(1'b1, 16'h5000);
        @(negedge clk);
        chk("t3_ack", {30'b0, wr_ack, mem_wr}, 3);
        chk("t3_dbusy", {31'b0, d_busy}, 1);
        cycle();
        wr_req = 0;
        @(negedge clk);
        chk("t3_gnt", {30'b0, mem_en, wr_ack}, 0);
        cycle();
        d_req = 0;
        watch(1'b1, dn, fn, en, le);
        chk("t3_done", dn, 12);
        chk("t3_fall", fn, 13);

        // 4: store held off during an I fill
        cycle();
        i_req = 1; i_addr = 16'h0100;
        push_fill(1'b0, 16'h0100);
        cycle();
        i_req = 0;
        wr_req = 1; wr_addr = 16'h7002; wr_data = 16'h1234;
        wr_q.push_back({16'h7002, 16'h1234});
        dn = 0; ack = 0; dbl = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (wr_ack) ack++;
            if (!d_busy) dbl++;
            if (fill_done) begin
                dn = n;
                break;
            end
            cycle();
        end
        chk("t4_done", dn, 12);
        chk("t4_noack", ack, 0);
        chk("t4_dbusy", dbl, 0);
        cycle();
        @(negedge clk);
        chk("t4_ack", {31'b0, wr_ack}, 1);
        chk("t4_ibusy", {31'b0, i_busy}, 0);
        cycle();
        wr_req = 0;
        @(negedge clk);
        chk("t4_once", {30'b0, wr_ack, d_busy}, 0);

        // 5: D drops req and moves address after grant
        cycle();
        d_req = 1; d_addr = 16'h8A4C;
        push_fill(1'b1, 16'h8A4C);
        cycle();
        d_req = 0; d_addr = 16'hFFFF;
        watch(1'b1, dn, fn, en, le);
        chk("t5_done", dn, 12);
        chk("t5_fall", fn, 13);
        chk("t5_en", en, 8);

        // 6: reset mid-fill after five issues
        cycle();
        i_req = 1; i_addr = 16'h2468;
        push_fill(1'b0, 16'h2468);
        cycle();
        i_req = 0;
        repeat (5) cycle();
        rst_n = 0;
        addr_q.delete();
        fill_q.delete();
        #1;
        chk_zero("t6_rst");
        cycle();
        rst_n = 1;
        stray = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (fill_we || fill_done || mem_en) stray++;
            cycle();
        end
        chk("t6_stray", stray, 0);
        i_req = 1; i_addr = 16'h2460;
        push_fill(1'b0, 16'h2460);
        cycle();
        i_req = 0;
        watch(1'b0, dn, fn, en, le);
        chk("t6_done", dn, 12);
        chk("t6_fall", fn, 13);

        cycle();
        cycle();
        chk("q_addr", addr_q.size(), 0);
        chk("q_fill", fill_q.size(), 0);
        chk("q_wr", wr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
